seg7_scan_display: RTL

Four-digit multiplexed seven-segment driver that consumes the BCD time digits and lap snapshot digits produced by the stopwatch top and scans them onto a common-anode display. It runs a refresh divider and a digit-select ring with an inter-digit ghosting guard. It captures and holds a lap readout for a fixed interval on request, and decodes BCD to active-low segments with decimal points at M.SS.T positions.

---
 rtl/stopwatch_pkg.sv | 32 +++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/seg7_scan_display.sv | 138 +++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: segment codes, anode and digit indices.
package stopwatch_pkg;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Active-low anodes, all digits dark
   localparam logic [3:0] ANODES_OFF = 4'b1111;

   // Digit positions, idx 3 is the leftmost digit
   localparam logic [1:0] DIG_MIN  = 2'd3;
   localparam logic [1:0] DIG_SMSD = 2'd2;
   localparam logic [1:0] DIG_SLSD = 2'd1;
   localparam logic [1:0] DIG_MS   = 2'd0;

   // Active-low one-cold anode pattern for a digit index
   function automatic logic [3:0] anode_sel(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; codes 10..15 show a dash.
module bcd_to_seg7
   import stopwatch_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg_c
);

   // Digit lookup with dash for invalid BCD
   always_comb begin
      o_seg_c = SEG_DASH;
      case (i_bcd)
         4'd0:    o_seg_c = SEG_0;
         4'd1:    o_seg_c = SEG_1;
         4'd2:    o_seg_c = SEG_2;
         4'd3:    o_seg_c = SEG_3;
         4'd4:    o_seg_c = SEG_4;
         4'd5:    o_seg_c = SEG_5;
         4'd6:    o_seg_c = SEG_6;
         4'd7:    o_seg_c = SEG_7;
         4'd8:    o_seg_c = SEG_8;
         4'd9:    o_seg_c = SEG_9;
         default: o_seg_c = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed seven-segment driver with ghosting guard and timed lap snapshot hold.
module seg7_scan_display
   import stopwatch_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned GUARD_CYCLES = 4,
   parameter int unsigned HOLD_CYCLES  = 100000000
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] minutes,
   input  logic [3:0] seconds_msd,
   input  logic [3:0] seconds_lsd,
   input  logic [3:0] ms_msd,
   input  logic [3:0] lap_minutes,
   input  logic [3:0] lap_seconds_msd,
   input  logic [3:0] lap_seconds_lsd,
   input  logic [3:0] lap_ms,
   input  logic       lap_show,
   input  logic       blank,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       lap_mode
);

   localparam int unsigned SC_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

   localparam logic [SC_W-1:0]   SC_LAST   = SC_W'(SCAN_DIV - 1);
   localparam logic [SC_W-1:0]   SC_GUARD  = SC_W'(GUARD_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

   logic [SC_W-1:0]   r_sc;
   logic [1:0]        r_idx;
   logic              r_lap_d;
   logic              r_lap_mode;
   logic [HOLD_W-1:0] r_hold;
   logic [3:0][3:0]   r_snap;
   logic [3:0]        r_an;
   logic [6:0]        r_seg;
   logic              r_dp;

   logic              w_lap_rise;
   logic              w_guard;
   logic              w_dp_on;
   logic [3:0][3:0]   w_live;
   logic [3:0][3:0]   w_src;
   logic [3:0]        w_digit;
   logic [6:0]        w_seg_c;

   assign w_lap_rise = lap_show & ~r_lap_d;
   assign w_guard    = (r_sc < SC_GUARD);
   assign w_dp_on    = (r_idx == DIG_MIN) || (r_idx == DIG_SLSD);
   assign w_live     = {minutes, seconds_msd, seconds_lsd, ms_msd};

   // Slot counter and digit ring; idx advances on the last cycle of each slot
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sc  <= '0;
         r_idx <= DIG_MS;
      end else if (r_sc == SC_LAST) begin
         r_sc  <= '0;
         r_idx <= r_idx + 2'd1;
      end else begin
         r_sc  <= r_sc + SC_W'(1);
      end
   end

   // Lap request edge detector
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lap_d <= 1'b0;
      end else begin
         r_lap_d <= lap_show;
      end
   end

   // Snapshot capture and hold timer; a new request beats expiry in the same cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_snap     <= '0;
         r_lap_mode <= 1'b0;
         r_hold     <= '0;
      end else if (w_lap_rise) begin
         r_snap     <= {lap_minutes, lap_seconds_msd, lap_seconds_lsd, lap_ms};
         r_lap_mode <= 1'b1;
         r_hold     <= HOLD_LOAD;
      end else if (r_lap_mode) begin
         if (r_hold == '0) begin
            r_lap_mode <= 1'b0;
         end else begin
            r_hold     <= r_hold - HOLD_W'(1);
         end
      end
   end

   // Source and digit select for the active slot
   always_comb begin
      w_src   = r_lap_mode ? r_snap : w_live;
      w_digit = w_src[DIG_MS];
      case (r_idx)
         DIG_MIN:  w_digit = w_src[DIG_MIN];
         DIG_SMSD: w_digit = w_src[DIG_SMSD];
         DIG_SLSD: w_digit = w_src[DIG_SLSD];
         default:  w_digit = w_src[DIG_MS];
      endcase
   end

   bcd_to_seg7 u_dec (
      .i_bcd   (w_digit),
      .o_seg_c (w_seg_c)
   );

   // Pin registers; guard window and blank force the display dark
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_an  <= ANODES_OFF;
         r_seg <= SEG_BLANK;
         r_dp  <= 1'b1;
      end else if (blank || w_guard) begin
         r_an  <= ANODES_OFF;
         r_seg <= SEG_BLANK;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= anode_sel(r_idx);
         r_seg <= w_seg_c;
         r_dp  <= ~w_dp_on;
      end
   end

   assign an       = r_an;
   assign seg      = r_seg;
   assign dp       = r_dp;
   assign lap_mode = r_lap_mode;

endmodule
